twdl_stage_sched: RTL and testbench

- Sequences the CORDIC twiddle coefficient generator through the stages of a 1200-point mixed-radix FFT frame (1200 = 4·4·5·5·3).
- Per stage, loads the generator's constant inputs (numerator, demoninator, twdl_quotient, twdl_remainder) from an internal table and pulses twdl_sop.
- Runs the stage for LEN cycles.
- Emits a valid/sop/eop/stage side-band delayed to align with the generator's coefficient outputs.
- Sits between the FFT stage controller and the twiddle generator instance.

---
 rtl/twdl_stage_sched.sv | 222 ++++++++++++++++++++++
 tb/tb_twdl_stage_sched.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/twdl_stage_sched.sv
// rtl/twdl_stage_sched.sv - stage sequencer feeding the CORDIC twiddle generator for a 1200-point FFT
module twdl_stage_sched #(
  parameter int LEN = 1200,
  parameter int LAT = 25,
  parameter int GAP = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [4:0]  stage_mask,
  input  logic        abort,
  input  logic        dn_ready,
  output logic        busy,
  output logic        done,
  output logic        twdl_sop,
  output logic [11:0] numerator,
  output logic [11:0] demoninator,
  output logic [19:0] twdl_quotient,
  output logic [11:0] twdl_remainder,
  output logic        coef_valid,
  output logic        coef_sop,
  output logic        coef_eop,
  output logic [2:0]  coef_stage
);

  typedef enum logic [2:0] {S_IDLE, S_SEL, S_WAIT, S_RUN, S_GAP, S_DRAIN} state_t;

  localparam logic [10:0] CNT_LAST = 11'(LEN - 1);
  localparam logic [10:0] GAP_LAST = 11'(GAP - 1);

  state_t            state_q, state_d;
  logic [4:0]        mask_q, mask_d;
  logic [10:0]       cnt_q, cnt_d;
  logic [2:0]        stage_q, stage_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              sop_q, sop_d;
  logic [11:0]       num_q, num_d;
  logic [11:0]       den_q, den_d;
  logic [19:0]       quo_q, quo_d;
  logic [11:0]       rem_q, rem_d;
  logic [LAT-1:0]    pv_q, pv_d;
  logic [LAT-1:0]    ps_q, ps_d;
  logic [LAT-1:0]    pe_q, pe_d;
  logic [LAT-1:0][2:0] pst_q, pst_d;

  logic              sel_found;
  logic [2:0]        sel_idx;
  logic [11:0]       tbl_num, tbl_den, tbl_rem;
  logic [19:0]       tbl_quo;
  logic              issue;

  // Lowest remaining mask bit; bits are cleared as stages finish, so order is ascending.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (mask_q[i]) begin
        sel_found = 1'b1;
        sel_idx   = 3'(i);
      end
    end
  end

  always_comb begin
    tbl_den = 12'd3;
    tbl_num = 12'd1;
    tbl_quo = 20'd349525;
    tbl_rem = 12'd1;
    case (sel_idx)
      3'd0: begin tbl_den = 12'd1200; tbl_num = 12'd300; tbl_quo = 20'd873;   tbl_rem = 12'd976; end
      3'd1: begin tbl_den = 12'd300;  tbl_num = 12'd75;  tbl_quo = 20'd3495;  tbl_rem = 12'd76;  end
      3'd2: begin tbl_den = 12'd75;   tbl_num = 12'd15;  tbl_quo = 20'd13981; tbl_rem = 12'd1;   end
      3'd3: begin tbl_den = 12'd15;   tbl_num = 12'd3;   tbl_quo = 20'd69905; tbl_rem = 12'd1;   end
      default: ;
    endcase
  end

  assign issue = (state_q == S_RUN);

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sop_d   = 1'b0;
    num_d   = num_q;
    den_d   = den_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    pv_d    = {pv_q[LAT-2:0], issue};
    ps_d    = {ps_q[LAT-2:0], issue && (cnt_q == 11'd0)};
    pe_d    = {pe_q[LAT-2:0], issue && (cnt_q == CNT_LAST)};
    pst_d   = {pst_q[LAT-2:0], stage_q};

    case (state_q)
      S_IDLE: begin
        if (start && (stage_mask != 5'd0)) begin
          mask_d  = stage_mask;
          busy_d  = 1'b1;
          state_d = S_SEL;
        end
      end
      S_SEL: begin
        if (!sel_found) begin
          state_d = S_DRAIN;
        end else begin
          stage_d = sel_idx;
          num_d   = tbl_num;
          den_d   = tbl_den;
          quo_d   = tbl_quo;
          rem_d   = tbl_rem;
          if (dn_ready) begin
            state_d = S_RUN;
            cnt_d   = 11'd0;
            sop_d   = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (dn_ready) begin
          state_d = S_RUN;
          cnt_d   = 11'd0;
          sop_d   = 1'b1;
        end
      end
      S_RUN: begin
        if (cnt_q == CNT_LAST) begin
          mask_d[stage_q] = 1'b0;
          cnt_d   = 11'd0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = 11'd0;
          state_d = S_SEL;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
      S_DRAIN: begin
        if (pv_q == '0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort drops everything in flight, including coefficients still in the alignment line.
    if (abort) begin
      state_d = S_IDLE;
      mask_d  = 5'd0;
      cnt_d   = 11'd0;
      stage_d = 3'd0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      sop_d   = 1'b0;
      pv_d    = '0;
      ps_d    = '0;
      pe_d    = '0;
      pst_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mask_q  <= 5'd0;
      cnt_q   <= 11'd0;
      stage_q <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sop_q   <= 1'b0;
      num_q   <= 12'd0;
      den_q   <= 12'd0;
      quo_q   <= 20'd0;
      rem_q   <= 12'd0;
      pv_q    <= '0;
      ps_q    <= '0;
      pe_q    <= '0;
      pst_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sop_q   <= sop_d;
      num_q   <= num_d;
      den_q   <= den_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      pv_q    <= pv_d;
      ps_q    <= ps_d;
      pe_q    <= pe_d;
      pst_q   <= pst_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign twdl_sop       = sop_q;
  assign numerator      = num_q;
  assign demoninator    = den_q;
  assign twdl_quotient  = quo_q;
  assign twdl_remainder = rem_q;
  assign coef_valid     = pv_q[LAT-1];
  assign coef_sop       = ps_q[LAT-1];
  assign coef_eop       = pe_q[LAT-1];
  assign coef_stage     = pst_q[LAT-1];

endmodule

// File: tb/tb_twdl_stage_sched.sv
// tb/tb_twdl_stage_sched.sv - randomized self-checking bench for twdl_stage_sched
`timescale 1ns/1ps
module tb_twdl_stage_sched;

  localparam int LEN = 1200;
  localparam int LAT = 25;
  localparam int GAP = 2;

  logic        clk = 1'b0;
  logic        rst, start, abort, dn_ready;
  logic [4:0]  stage_mask;
  logic        busy, done, twdl_sop, coef_valid, coef_sop, coef_eop;
  logic [11:0] numerator, demoninator, twdl_remainder;
  logic [19:0] twdl_quotient;
  logic [2:0]  coef_stage;

  twdl_stage_sched #(.LEN(LEN), .LAT(LAT), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .start(start), .stage_mask(stage_mask), .abort(abort),
    .dn_ready(dn_ready), .busy(busy), .done(done), .twdl_sop(twdl_sop),
    .numerator(numerator), .demoninator(demoninator), .twdl_quotient(twdl_quotient),
    .twdl_remainder(twdl_remainder), .coef_valid(coef_valid), .coef_sop(coef_sop),
    .coef_eop(coef_eop), .coef_stage(coef_stage)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  int done_cnt = 0, sop_cnt = 0, coef_cnt = 0;
  int exp_first_sop = -1, last_sop = -1;
  bit spacing_on = 0, in_stage = 0, rand_dn = 0;
  int radix[5] = '{4, 4, 5, 5, 3};
  int tbl_d[5], tbl_p[5], tbl_q[5], tbl_r[5];
  logic [4:0] exp_coef[$];
  int exp_row[$];
  int sop_times[$];
  int m_s, m_t;
  logic [4:0] m_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: each enabled stage, ascending, yields LEN coefficients tagged sop/eop/stage.
  function automatic void build_expect(input logic [4:0] m);
    for (int s = 0; s < 5; s++) begin
      if (m[s]) begin
        exp_row.push_back(s);
        for (int i = 0; i < LEN; i++) exp_coef.push_back({(i == 0), (i == LEN - 1), 3'(s)});
      end
    end
  endfunction

  function automatic void flush_model();
    exp_coef.delete();
    exp_row.delete();
    sop_times.delete();
    in_stage = 0;
    exp_first_sop = -1;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (twdl_sop) begin
        sop_cnt++;
        if (exp_first_sop >= 0) begin
          check_eq("first_sop_cycle", cyc, exp_first_sop);
          exp_first_sop = -1;
        end
        if (spacing_on && last_sop >= 0) check_eq("sop_spacing", cyc - last_sop, LEN + GAP + 1);
        last_sop = cyc;
        if (exp_row.size() == 0) begin
          check_eq("sop_unexpected", twdl_sop, 0);
        end else begin
          m_s = exp_row.pop_front();
          check_eq("numerator", numerator, tbl_p[m_s]);
          check_eq("demoninator", demoninator, tbl_d[m_s]);
          check_eq("quotient", twdl_quotient, tbl_q[m_s]);
          check_eq("remainder", twdl_remainder, tbl_r[m_s]);
          sop_times.push_back(cyc);
        end
      end
      if (coef_valid) begin
        coef_cnt++;
        if (exp_coef.size() == 0) begin
          check_eq("coef_unexpected", coef_valid, 0);
        end else begin
          m_e = exp_coef.pop_front();
          check_eq("coef_sb", {coef_sop, coef_eop, coef_stage}, m_e);
        end
        if (coef_sop) begin
          if (sop_times.size() == 0) check_eq("lat_orphan", coef_sop, 0);
          else begin
            m_t = sop_times.pop_front();
            check_eq("sop_to_coef_lat", cyc - m_t, LAT);
          end
          in_stage = 1;
        end
        if (coef_eop) in_stage = 0;
      end else begin
        check_eq("sb_stray", {coef_sop, coef_eop}, 0);
        if (in_stage) check_eq("coef_contig", coef_valid, 1);
      end
      if (done) begin
        done_cnt++;
        check_eq("done_drained", exp_coef.size(), 0);
        check_eq("busy_at_done", busy, 0);
      end
    end
  end

  task automatic start_frame(input logic [4:0] m);
    start = 1'b1;
    stage_mask = m;
    if (m != 5'd0) build_expect(m);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_cnt;
    bit seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (done_cnt != d0) begin
        seen = 1;
        break;
      end
      if (rand_dn) begin
        dn_ready = 1'($urandom_range(0, 1));
        if (busy && $urandom_range(0, 99) == 0) begin
          start = 1'b1;
          stage_mask = 5'($urandom_range(0, 31));
        end else start = 1'b0;
      end
    end
    start = 1'b0;
    check_eq("done_seen", seen, 1);
    repeat (5) @(posedge clk);
    #1;
    check_eq("done_once", done_cnt - d0, 1);
    check_eq("idle_busy", busy, 0);
  endtask

  task automatic wait_sop(input int target, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (sop_cnt >= target) begin
        seen = 1;
        break;
      end
    end
    check_eq("sop_seen", seen, 1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int d0, s0, c0, dd;
    logic [4:0] m;
    dd = 1200;
    for (int s = 0; s < 5; s++) begin
      tbl_d[s] = dd;
      tbl_p[s] = dd / radix[s];
      tbl_q[s] = (1 << 20) / dd;
      tbl_r[s] = (1 << 20) % dd;
      dd = tbl_p[s];
    end

    rst = 1'b1; start = 1'b0; abort = 1'b0; dn_ready = 1'b0; stage_mask = 5'd0;
    #1;
    check_eq("reset_ctrl", {busy, done, twdl_sop, coef_valid, coef_sop, coef_eop, coef_stage}, 0);
    check_eq("reset_tbl", {numerator, demoninator, twdl_quotient, twdl_remainder}, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // single stage 0
    dn_ready = 1'b1;
    exp_first_sop = cyc + 2;
    start_frame(5'b00001);
    check_eq("busy_after_start", busy, 1);
    wait_done(2000);

    // full frame, with a start pulse while busy that must be ignored
    spacing_on = 1; last_sop = -1;
    s0 = sop_cnt; c0 = coef_cnt;
    exp_first_sop = cyc + 2;
    start_frame(5'b11111);
    repeat (100) @(posedge clk);
    #1 start = 1'b1; stage_mask = 5'b00001;
    @(posedge clk); #1 start = 1'b0;
    wait_done(8000);
    spacing_on = 0;
    check_eq("full_sops", sop_cnt - s0, 5);
    check_eq("full_coefs", coef_cnt - c0, 5 * LEN);

    // stages 2 and 4 with downstream stall before stage 2
    dn_ready = 1'b0;
    start_frame(5'b10100);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check_eq("wait_hold", {numerator, demoninator, twdl_quotient, twdl_remainder},
               {12'(tbl_p[2]), 12'(tbl_d[2]), 20'(tbl_q[2]), 12'(tbl_r[2])});
      check_eq("wait_no_sop", twdl_sop, 0);
    end
    dn_ready = 1'b1;
    exp_first_sop = cyc + 1;
    wait_done(4000);

    // abort 500 issues into stage 1, together with a start that must be dropped
    s0 = sop_cnt;
    exp_first_sop = cyc + 2;
    start_frame(5'b00011);
    wait_sop(s0 + 2, 3000);
    repeat (499) @(posedge clk);
    #1;
    abort = 1'b1; start = 1'b1; stage_mask = 5'b00001;
    d0 = done_cnt;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    flush_model();
    check_eq("abort_busy", busy, 0);
    check_eq("abort_coef_valid", coef_valid, 0);
    @(posedge clk); #1;
    check_eq("abort_start_dropped", busy, 0);
    check_eq("abort_no_done", done_cnt, d0);
    exp_first_sop = cyc + 2;
    start_frame(5'b00001);
    check_eq("restart_busy", busy, 1);
    wait_done(2000);

    // asynchronous reset mid-run
    s0 = sop_cnt;
    exp_first_sop = cyc + 2;
    start_frame(5'b00001);
    wait_sop(s0 + 1, 100);
    repeat (100) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    flush_model();
    check_eq("async_rst_ctrl", {busy, done, twdl_sop, coef_valid, coef_sop, coef_eop, coef_stage}, 0);
    check_eq("async_rst_tbl", {numerator, demoninator, twdl_quotient, twdl_remainder}, 0);
    @(posedge clk); #1 rst = 1'b0;
    d0 = done_cnt; s0 = sop_cnt; c0 = coef_cnt;
    start_frame(5'b00000);
    repeat (50) @(posedge clk);
    #1;
    check_eq("mask0_busy", busy, 0);
    check_eq("mask0_done", done_cnt, d0);
    check_eq("mask0_sop", sop_cnt, s0);
    check_eq("mask0_coef", coef_cnt, c0);

    // randomized masks with random downstream readiness
    rand_dn = 1;
    for (int k = 0; k < 3; k++) begin
      m = 5'($urandom_range(1, 31));
      c0 = coef_cnt;
      start_frame(m);
      wait_done(15000);
      check_eq("rand_coefs", coef_cnt - c0, $countones(m) * LEN);
    end
    rand_dn = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
